multi_gamepad_scanner: RTL

Parametrised successor to the single-pad Mega Drive/Genesis gamepad controller. It scans NUM_PADS DB-9 pads through one shared select line and supports both 3-button and 6-button pads, with per-pad presence and type detection. Each scan is started by the composer's new-frame strobe. Results are published atomically at the end of the scan, together with one-cycle press-edge pulses, on the clk_sys domain, for the gamepad PIO.

---
 rtl/multi_gamepad_scanner.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/multi_gamepad_scanner.sv
// Scans NUM_PADS Mega Drive/Genesis pads over one shared select line, detecting
// presence and 3/6-button type, and publishes all results atomically in one commit cycle.
module multi_gamepad_scanner #(
    parameter int NUM_PADS        = 2,
    parameter int SETTLE_CYCLES   = 500,
    parameter int SIX_BUTTON      = 1,
    parameter int IDLE_GAP_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [6*NUM_PADS-1:0]  pad_pins,
    output logic                   select,
    output logic [12*NUM_PADS-1:0] btn_out,
    output logic [12*NUM_PADS-1:0] btn_pressed,
    output logic [NUM_PADS-1:0]    pad_present,
    output logic [NUM_PADS-1:0]    pad_six,
    output logic                   scan_done,
    output logic                   busy
);

    localparam int NUM_PHASES = (SIX_BUTTON != 0) ? 8 : 2;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int GW = (IDLE_GAP_CYCLES > 0) ? $clog2(IDLE_GAP_CYCLES + 1) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(IDLE_GAP_CYCLES - 1);
    localparam logic [2:0]    PHASE_LAST  = 3'(NUM_PHASES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_GAP} state_t;

    state_t state_q, state_d;

    logic [6*NUM_PADS-1:0]         pin_meta, pin_sync;
    logic [NUM_PADS-1:0][5:0]      pin_low;
    logic [SW-1:0]                 settle_q;
    logic [2:0]                    phase_q;
    logic [GW-1:0]                 gap_q;
    logic                          phase_end, gap_end;

    logic [NUM_PADS-1:0][11:0]     sh_btn;
    logic [NUM_PADS-1:0]           sh_present, sh_six;
    logic [NUM_PADS-1:0][11:0]     commit_btn, held_btn;
    logic [NUM_PADS-1:0]           commit_six, held_present, held_six;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_meta <= '0;
            pin_sync <= '0;
        end else begin
            pin_meta <= pad_pins;
            pin_sync <= pin_meta;
        end
    end

    // Pins are active-low; work with the inverted view from here on.
    assign pin_low   = ~pin_sync;
    assign phase_end = (state_q == S_SCAN) && (settle_q == SETTLE_LAST);
    assign gap_end   = (state_q == S_GAP) &&
                       ((IDLE_GAP_CYCLES == 0) || (gap_q == GAP_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (enable) state_d = S_SCAN;
            S_SCAN:   if (phase_end && (phase_q == PHASE_LAST)) state_d = S_COMMIT;
            S_COMMIT: state_d = S_GAP;
            S_GAP:    if (gap_end) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        select      = 1'b1;
        busy        = 1'b0;
        scan_done   = 1'b0;
        btn_out     = held_btn;
        btn_pressed = '0;
        pad_present = held_present;
        pad_six     = held_six;
        case (state_q)
            S_SCAN: begin
                select = ~phase_q[0];
                busy   = 1'b1;
            end
            S_COMMIT: begin
                busy        = 1'b1;
                scan_done   = 1'b1;
                btn_out     = commit_btn;
                btn_pressed = commit_btn & ~held_btn;
                pad_present = sh_present;
                pad_six     = commit_six;
            end
            default: ;
        endcase
    end

    // Every counter restarts from zero on each phase or state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= '0;
            phase_q  <= '0;
            gap_q    <= '0;
        end else begin
            if ((state_q != S_SCAN) || phase_end) settle_q <= '0;
            else                                  settle_q <= settle_q + SW'(1);

            if ((state_q != S_SCAN) || (phase_end && (phase_q == PHASE_LAST))) phase_q <= '0;
            else if (phase_end)                                                phase_q <= phase_q + 3'd1;

            if (state_q != S_GAP) gap_q <= '0;
            else                  gap_q <= gap_q + GW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_btn     <= '0;
            sh_present <= '0;
            sh_six     <= '0;
        end else if (phase_end) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                case (phase_q)
                    3'd0: begin
                        sh_btn[p][6]   <= pin_low[p][5];
                        sh_btn[p][5]   <= pin_low[p][4];
                        sh_btn[p][3:0] <= pin_low[p][3:0];
                    end
                    3'd1: begin
                        sh_btn[p][7]  <= pin_low[p][5];
                        sh_btn[p][4]  <= pin_low[p][4];
                        sh_present[p] <= pin_low[p][2] & pin_low[p][3];
                    end
                    3'd5: sh_six[p] <= &pin_low[p][3:0];
                    3'd6: sh_btn[p][11:8] <= sh_six[p] ? pin_low[p][3:0] : 4'b0000;
                    default: ;
                endcase
            end
        end
    end

    // Absent pads report nothing; extended buttons only count on a detected 6-button pad.
    always_comb begin
        commit_six = '0;
        commit_btn = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            commit_six[p] = (SIX_BUTTON != 0) && sh_present[p] && sh_six[p];
            if (sh_present[p]) begin
                commit_btn[p][7:0]  = sh_btn[p][7:0];
                commit_btn[p][11:8] = commit_six[p] ? sh_btn[p][11:8] : 4'b0000;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_btn     <= '0;
            held_present <= '0;
            held_six     <= '0;
        end else if (state_q == S_COMMIT) begin
            held_btn     <= commit_btn;
            held_present <= sh_present;
            held_six     <= commit_six;
        end
    end

endmodule
